// File: rtl/iq_accumulator_pkg.sv
// Shared widths, FSM encoding and saturation limits for the I/Q readout accumulator.
// ACC_W_DEF must track the state discriminator input width.
package iq_accumulator_pkg;

    localparam int SAMPLE_W_DEF = 16;
    localparam int ACC_W_DEF    = 32;
    localparam int CNT_W_DEF    = 16;
    localparam int MISS_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_INTEGRATE,
        ST_EMIT
    } acc_state_t;

    function automatic longint acc_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint acc_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/iq_accumulator_if.sv
// Sample stream, readout control and result bus between the ADC front end,
// the accumulator and the state discriminator.
interface iq_accumulator_if #(
    parameter int SAMPLE_W = 16,
    parameter int ACC_W    = 32,
    parameter int CNT_W    = 16
);
    logic                       readout_trigger;
    logic [CNT_W-1:0]           delay_len;
    logic [CNT_W-1:0]           window_len;
    logic                       sample_valid;
    logic signed [SAMPLE_W-1:0] adc_i;
    logic signed [SAMPLE_W-1:0] adc_q;
    logic [2*ACC_W-1:0]         accumulated_data;
    logic                       start_trigger;
    logic                       busy;
    logic                       saturated;
    logic [7:0]                 missed_triggers;

    modport master (
        output readout_trigger, delay_len, window_len, sample_valid, adc_i, adc_q,
        input  accumulated_data, start_trigger, busy, saturated, missed_triggers
    );

    modport slave (
        input  readout_trigger, delay_len, window_len, sample_valid, adc_i, adc_q,
        output accumulated_data, start_trigger, busy, saturated, missed_triggers
    );
endinterface

// File: rtl/iq_accumulator_sat_add.sv
// One accumulator lane: signed accumulator plus sign-extended sample, clipped to
// the accumulator range, with a flag when clipping occurred.
module iq_sat_add
    import iq_accumulator_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ACC_W    = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0]    acc,
    input  logic signed [SAMPLE_W-1:0] sample,
    output logic signed [ACC_W-1:0]    sum,
    output logic                       clip
);
    localparam logic signed [ACC_W-1:0] LIM_MAX = ACC_W'(acc_max(ACC_W));
    localparam logic signed [ACC_W-1:0] LIM_MIN = ACC_W'(acc_min(ACC_W));

    logic signed [ACC_W:0] acc_x;
    logic signed [ACC_W:0] samp_x;
    logic signed [ACC_W:0] wide;

    function automatic logic signed [ACC_W-1:0] sat_clip(input logic signed [ACC_W:0] w);
        if (w[ACC_W] != w[ACC_W-1]) begin
            return w[ACC_W] ? LIM_MIN : LIM_MAX;
        end
        return $signed(w[ACC_W-1:0]);
    endfunction

    assign acc_x  = (ACC_W+1)'(acc);
    assign samp_x = (ACC_W+1)'(sample);
    assign wide   = acc_x + samp_x;
    assign sum    = sat_clip(wide);
    assign clip   = wide[ACC_W] ^ wide[ACC_W-1];
endmodule

// File: rtl/iq_accumulator.sv
// Integrates valid I/Q samples over a triggered readout window and presents one
// held result per trigger to the discriminator together with a 1-cycle start strobe.
module iq_accumulator
    import iq_accumulator_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    iq_accumulator_if.slave bus
);
    acc_state_t              state, state_nxt;
    logic [CNT_W-1:0]        dly_rem, win_rem;
    logic signed [ACC_W-1:0] acc_i, acc_q, sum_i, sum_q;
    logic signed [ACC_W-1:0] res_i_p1, res_q_p1;
    logic                    clip_i, clip_q, sat_shadow, sat_p1, vld_p1;
    logic [MISS_W-1:0]       missed;
    logic                    trig, take, last_sample;

    assign trig        = bus.readout_trigger;
    assign take        = bus.sample_valid;
    assign last_sample = (state == ST_INTEGRATE) && take && (win_rem == CNT_W'(1));

    iq_sat_add #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_add_i (
        .acc(acc_i), .sample(bus.adc_i), .sum(sum_i), .clip(clip_i)
    );

    iq_sat_add #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_add_q (
        .acc(acc_q), .sample(bus.adc_q), .sum(sum_q), .clip(clip_q)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:      if (trig) state_nxt = (bus.delay_len != '0) ? ST_DELAY : ST_INTEGRATE;
            ST_DELAY:     if (take && dly_rem == CNT_W'(1)) state_nxt = ST_INTEGRATE;
            ST_INTEGRATE: if (last_sample) state_nxt = ST_EMIT;
            ST_EMIT:      state_nxt = ST_IDLE;
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Window counters and lane accumulators; result stage _p1 loads with the last sample
    always_ff @(posedge clk) begin
        if (rst) begin
            dly_rem    <= '0;
            win_rem    <= '0;
            acc_i      <= '0;
            acc_q      <= '0;
            sat_shadow <= 1'b0;
            res_i_p1   <= '0;
            res_q_p1   <= '0;
            sat_p1     <= 1'b0;
            vld_p1     <= 1'b0;
            missed     <= '0;
        end else begin
            vld_p1 <= last_sample;
            if (trig && state != ST_IDLE && missed != '1) missed <= missed + MISS_W'(1);
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        dly_rem    <= bus.delay_len;
                        win_rem    <= (bus.window_len == '0) ? CNT_W'(1) : bus.window_len;
                        acc_i      <= '0;
                        acc_q      <= '0;
                        sat_shadow <= 1'b0;
                    end
                end
                ST_DELAY: begin
                    if (take) dly_rem <= dly_rem - CNT_W'(1);
                end
                ST_INTEGRATE: begin
                    if (take) begin
                        acc_i      <= sum_i;
                        acc_q      <= sum_q;
                        sat_shadow <= sat_shadow | clip_i | clip_q;
                        win_rem    <= win_rem - CNT_W'(1);
                    end
                    if (last_sample) begin
                        res_i_p1 <= sum_i;
                        res_q_p1 <= sum_q;
                        sat_p1   <= sat_shadow | clip_i | clip_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.accumulated_data = {res_i_p1, res_q_p1};
    assign bus.start_trigger    = vld_p1;
    assign bus.saturated        = sat_p1;
    assign bus.busy             = (state != ST_IDLE);
    assign bus.missed_triggers  = missed;
endmodule

// File: tb/tb_iq_accumulator.sv
// Randomized scoreboard bench for iq_accumulator built with a 20-bit accumulator
// so that lane saturation is reachable with short windows.
module tb_iq_accumulator;
    localparam int SW = 16;
    localparam int AW = 20;
    localparam int CW = 16;
    localparam longint LMAX = 524287;
    localparam longint LMIN = -524288;

    typedef struct {
        longint i;
        longint q;
        bit     sat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iq_accumulator_if #(.SAMPLE_W(SW), .ACC_W(AW), .CNT_W(CW)) bus ();

    iq_accumulator #(.SAMPLE_W(SW), .ACC_W(AW), .CNT_W(CW)) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   exp_missed = 0;
    exp_t exp_q[$];
    int   exp_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic longint missed_model();
        return (exp_missed > 255) ? 255 : exp_missed;
    endfunction

    // Monitor: every strobe cycle pops one expected result
    logic signed [AW-1:0] mon_i, mon_q;
    exp_t mon_e;
    always @(negedge clk) begin
        if (bus.start_trigger) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                mon_i = bus.accumulated_data[2*AW-1:AW];
                mon_q = bus.accumulated_data[AW-1:0];
                check("acc_i", longint'(mon_i), mon_e.i);
                check("acc_q", longint'(mon_q), mon_e.q);
                check("saturated", longint'(bus.saturated), longint'(mon_e.sat));
                if (exp_cyc_q.size() == 0) check("strobe_cycle_missing", 1, 0);
                else check("strobe_cycle", cyc, exp_cyc_q.pop_front() + 1);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_noise(input bit vld);
        bus.sample_valid = vld;
        bus.adc_i        = SW'($urandom);
        bus.adc_q        = SW'($urandom);
    endtask

    task automatic drive_idle(input int n);
        for (int c = 0; c < n; c++) begin
            bus.readout_trigger = 1'b0;
            drive_noise(1'($urandom));
            next_cycle();
        end
    endtask

    // gap: percentage of idle sample cycles, 200 = alternate (gap first)
    // mode: 0 small random, 1 constant ci/cq, 2 ramp +n/-n, 3 large values
    // trig_mode: 0 none, 1 one extra trigger mid-window, 2 extra trigger every window cycle
    task automatic run_window(input int dly, input int win, input int gap, input int mode,
                              input int ci, input int cq, input int trig_mode, input bit trig_emit);
        logic signed [SW-1:0] si[$];
        logic signed [SW-1:0] sq[$];
        logic signed [SW-1:0] vi, vq;
        longint ai, aq;
        bit     sat, v;
        int     n, k, j;
        exp_t   e;
        n = dly + ((win == 0) ? 1 : win);
        for (int x = 0; x < n; x++) begin
            if (x < dly) begin
                vi = SW'($urandom);
                vq = SW'($urandom);
            end else begin
                case (mode)
                    1:       begin vi = SW'(ci); vq = SW'(cq); end
                    2:       begin vi = SW'(x - dly + 1); vq = SW'(-(x - dly + 1)); end
                    3:       begin
                                 vi = ($urandom_range(0, 3) != 0) ? 16'sh7fff : SW'($urandom);
                                 vq = ($urandom_range(0, 3) != 0) ? 16'sh8000 : SW'($urandom);
                             end
                    default: begin
                                 vi = SW'(int'($urandom_range(0, 2000)) - 1000);
                                 vq = SW'(int'($urandom_range(0, 2000)) - 1000);
                             end
                endcase
            end
            si.push_back(vi);
            sq.push_back(vq);
        end
        ai = 0; aq = 0; sat = 1'b0;
        for (int x = dly; x < n; x++) begin
            ai += longint'(si[x]);
            aq += longint'(sq[x]);
            if (ai > LMAX) begin ai = LMAX; sat = 1'b1; end
            if (ai < LMIN) begin ai = LMIN; sat = 1'b1; end
            if (aq > LMAX) begin aq = LMAX; sat = 1'b1; end
            if (aq < LMIN) begin aq = LMIN; sat = 1'b1; end
        end
        e.i = ai; e.q = aq; e.sat = sat;
        exp_q.push_back(e);

        bus.readout_trigger = 1'b1;
        bus.delay_len       = CW'(dly);
        bus.window_len      = CW'(win);
        drive_noise(1'b1);
        next_cycle();
        bus.delay_len  = CW'($urandom);
        bus.window_len = CW'($urandom);

        k = 0; j = 0;
        while (k < n) begin
            v = (gap == 200) ? (j % 2 == 1) : (int'($urandom_range(0, 99)) >= gap);
            bus.readout_trigger = (trig_mode == 1 && j == 1) || (trig_mode == 2 && j >= 1);
            if (bus.readout_trigger) exp_missed++;
            if (v) begin
                bus.sample_valid = 1'b1;
                bus.adc_i        = si[k];
                bus.adc_q        = sq[k];
                k++;
                if (k == n) exp_cyc_q.push_back(cyc);
            end else begin
                drive_noise(1'b0);
            end
            next_cycle();
            j++;
        end

        check("busy_emit", longint'(bus.busy), 1);
        bus.readout_trigger = trig_emit;
        if (trig_emit) exp_missed++;
        drive_noise(1'($urandom));
        next_cycle();
        bus.readout_trigger = 1'b0;
        check("busy_after", longint'(bus.busy), 0);
        check("missed_triggers", longint'(bus.missed_triggers), missed_model());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},   longint'(bus.accumulated_data), 0);
        check({tag, "_strobe"}, longint'(bus.start_trigger), 0);
        check({tag, "_busy"},   longint'(bus.busy), 0);
        check({tag, "_sat"},    longint'(bus.saturated), 0);
        check({tag, "_missed"}, longint'(bus.missed_triggers), 0);
    endtask

    task automatic abort_by_reset();
        bus.readout_trigger = 1'b1;
        bus.delay_len       = CW'(1);
        bus.window_len      = CW'(20);
        drive_noise(1'b1);
        next_cycle();
        bus.readout_trigger = 1'b0;
        for (int c = 0; c < 6; c++) begin
            bus.sample_valid = 1'b1;
            bus.adc_i        = 16'sd1234;
            bus.adc_q        = -16'sd999;
            next_cycle();
        end
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        exp_missed = 0;
        check_reset_outputs("mid_reset");
    endtask

    initial begin
        bus.readout_trigger = 1'b0;
        bus.delay_len       = '0;
        bus.window_len      = '0;
        bus.sample_valid    = 1'b0;
        bus.adc_i           = '0;
        bus.adc_q           = '0;
        rst = 1'b1;
        repeat (3) next_cycle();
        check_reset_outputs("reset");
        rst = 1'b0;
        drive_idle(3);

        run_window(2, 4, 0, 1, 100, -50, 0, 1'b0);
        drive_idle(2);
        run_window(0, 3, 200, 2, 0, 0, 0, 1'b0);
        drive_idle(1);
        run_window(0, 0, 0, 1, 7, 7, 0, 1'b0);
        drive_idle(2);
        run_window(1, 20, 0, 1, 32767, -32768, 0, 1'b0);
        drive_idle(2);
        run_window(0, 5, 10, 0, 0, 0, 0, 1'b0);
        drive_idle(2);
        run_window(1, 6, 0, 1, 11, 22, 1, 1'b1);
        drive_idle(2);

        for (int r = 0; r < 40; r++) begin
            run_window(int'($urandom_range(0, 5)), int'($urandom_range(0, 30)),
                       int'($urandom_range(0, 50)), int'($urandom_range(0, 3)),
                       0, 0, int'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
            drive_idle(int'($urandom_range(0, 3)));
        end

        run_window(0, 270, 0, 0, 0, 0, 2, 1'b1);
        drive_idle(2);
        run_window(0, 2, 0, 1, 3, 4, 1, 1'b0);
        drive_idle(2);

        abort_by_reset();
        drive_idle(3);
        run_window(0, 4, 0, 1, 5, -6, 0, 1'b0);
        drive_idle(2);

        for (int c = 0; c < 200 && exp_q.size() != 0; c++) next_cycle();
        check("pending_results", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
